// File: rtl/rv_uart_soc_top.sv
// UART/debug front end: RX/TX byte FIFOs, echo or 32-bit word packing, LEDs and 8-digit seven-seg.
// Defining UART_PARITY_EN switches both UART directions from 8N1 to 8E1 framing.
module rv_uart_soc_top #(
  parameter int          CLKS_PER_BIT = 900,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          REFRESH_BITS = 16,
  parameter logic [95:0] KEY_VALUE    = 96'h3cf3cf3cf3cf_30c30c_bae_3cf
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        rx,
  input  logic        prog,
  input  logic        debug,
  input  logic [4:0]  debug_input,
  input  logic [95:0] key,
  output logic        tx,
  output logic        clk_out,
  output logic [6:0]  sev_out,
  output logic [7:0]  an,
  output logic [15:0] led
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } uart_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  logic        w_key_ok;
  logic [7:0]  w_mask;
  assign w_key_ok = (key == KEY_VALUE);
  assign w_mask   = key[7:0] ^ KEY_VALUE[7:0];

  // ---------------- UART receiver ----------------
  uart_state_t   r_rx_st;
  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sr;
  logic          r_rx_done, r_rx_ferr;
  logic          w_rx_ok;
`ifdef UART_PARITY_EN
  logic          r_rx_perr;
  assign w_rx_ok = r_rx_s2 & ~r_rx_perr;
`else
  assign w_rx_ok = r_rx_s2;
`endif

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_d    <= 1'b1;
      r_rx_st   <= S_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sr   <= '0;
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_perr <= 1'b0;
`endif
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_d    <= r_rx_s2;
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_cnt  <= r_rx_cnt + 1'b1;
      case (r_rx_st)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_d && !r_rx_s2) r_rx_st <= S_START;
        end
        S_START: if (r_rx_cnt == HALF_LAST) begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
          r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (r_rx_cnt == BIT_LAST) begin
          r_rx_cnt <= '0;
          r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
`ifdef UART_PARITY_EN
          if (r_rx_bit == 3'd7) r_rx_st <= S_PAR;
        end
        S_PAR: if (r_rx_cnt == BIT_LAST) begin
          r_rx_cnt  <= '0;
          r_rx_perr <= (r_rx_s2 != ^r_rx_sr);
          r_rx_st   <= S_STOP;
`else
          if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
`endif
        end
        S_STOP: if (r_rx_cnt == BIT_LAST) begin
          r_rx_cnt  <= '0;
          r_rx_st   <= S_IDLE;
          r_rx_done <= w_rx_ok;
          r_rx_ferr <= ~w_rx_ok;
        end
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and error counters ----------------
  logic [7:0]  r_rxf_mem [FIFO_DEPTH];
  logic [AW:0] r_rxf_wp, r_rxf_rp;
  logic [7:0]  r_ovr_err, r_frm_err;
  logic        w_rxf_empty, w_rxf_full, w_rxf_push;
  logic [7:0]  w_rx_byte;
  assign w_rxf_empty = (r_rxf_wp == r_rxf_rp);
  assign w_rxf_full  = (r_rxf_wp[AW] != r_rxf_rp[AW]) && (r_rxf_wp[AW-1:0] == r_rxf_rp[AW-1:0]);
  assign w_rxf_push  = r_rx_done && !w_rxf_full;
  assign w_rx_byte   = r_rxf_mem[r_rxf_rp[AW-1:0]];

  always_ff @(posedge clk) if (w_rxf_push) r_rxf_mem[r_rxf_wp[AW-1:0]] <= r_rx_sr ^ w_mask;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_ovr_err <= '0;
      r_frm_err <= '0;
    end else begin
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
      if (!w_rxf_empty) r_rxf_rp <= r_rxf_rp + 1'b1;
      if (r_rx_done && w_rxf_full) r_ovr_err <= sat_inc8(r_ovr_err);
      if (r_rx_ferr) r_frm_err <= sat_inc8(r_frm_err);
    end
  end

  // ---------------- Consumer: echo or word packing ----------------
  logic [7:0]  r_txf_mem [FIFO_DEPTH];
  logic [AW:0] r_txf_wp, r_txf_rp;
  logic        w_txf_empty, w_txf_full, w_txf_push, w_mode_chg;
  logic [7:0]  w_tx_byte, r_led_byte;
  logic [31:0] r_disp, r_word_sr, r_prog_word;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_bcnt, w_bcnt;
  logic        r_prog_d;
  assign w_txf_empty = (r_txf_wp == r_txf_rp);
  assign w_txf_full  = (r_txf_wp[AW] != r_txf_rp[AW]) && (r_txf_wp[AW-1:0] == r_txf_rp[AW-1:0]);
  assign w_txf_push  = !w_rxf_empty && !prog && !w_txf_full;
  assign w_tx_byte   = r_txf_mem[r_txf_rp[AW-1:0]];
  assign w_mode_chg  = (prog != r_prog_d);
  assign w_bcnt      = w_mode_chg ? 2'd0 : r_bcnt;

  always_ff @(posedge clk) if (w_txf_push) r_txf_mem[r_txf_wp[AW-1:0]] <= w_rx_byte;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_txf_wp    <= '0;
      r_led_byte  <= '0;
      r_disp      <= '0;
      r_word_sr   <= '0;
      r_prog_word <= '0;
      r_word_cnt  <= '0;
      r_bcnt      <= '0;
      r_prog_d    <= 1'b0;
    end else begin
      r_prog_d <= prog;
      if (w_mode_chg) r_bcnt <= '0;
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (!w_rxf_empty) begin
        if (!prog) begin
          r_led_byte <= w_rx_byte;
          r_disp     <= {r_disp[23:0], w_rx_byte};
        end else begin
          r_word_sr <= {w_rx_byte, r_word_sr[31:8]};
          r_bcnt    <= w_bcnt + 1'b1;
          if (w_bcnt == 2'd3) begin
            r_prog_word <= {w_rx_byte, r_word_sr[31:8]};
            r_word_cnt  <= r_word_cnt + 1'b1;
          end
        end
      end
    end
  end

  // ---------------- UART transmitter ----------------
  uart_state_t   r_tx_st;
  logic          r_tx;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sr;
`ifdef UART_PARITY_EN
  logic          r_tx_par;
`endif

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_tx_st  <= S_IDLE;
      r_tx     <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sr  <= '0;
      r_txf_rp <= '0;
`ifdef UART_PARITY_EN
      r_tx_par <= 1'b0;
`endif
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
      case (r_tx_st)
        S_IDLE: begin
          r_tx_cnt <= '0;
          r_tx     <= 1'b1;
          if (!w_txf_empty) begin
            r_tx_sr  <= w_tx_byte;
            r_txf_rp <= r_txf_rp + 1'b1;
            r_tx     <= 1'b0;
            r_tx_st  <= S_START;
`ifdef UART_PARITY_EN
            r_tx_par <= ^w_tx_byte;
`endif
          end
        end
        S_START: if (r_tx_cnt == BIT_LAST) begin
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          r_tx     <= r_tx_sr[0];
          r_tx_sr  <= {1'b0, r_tx_sr[7:1]};
          r_tx_st  <= S_DATA;
        end
        S_DATA: if (r_tx_cnt == BIT_LAST) begin
          r_tx_cnt <= '0;
          r_tx_bit <= r_tx_bit + 1'b1;
          if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            r_tx    <= r_tx_par;
            r_tx_st <= S_PAR;
`else
            r_tx    <= 1'b1;
            r_tx_st <= S_STOP;
`endif
          end else begin
            r_tx    <= r_tx_sr[0];
            r_tx_sr <= {1'b0, r_tx_sr[7:1]};
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (r_tx_cnt == BIT_LAST) begin
          r_tx_cnt <= '0;
          r_tx     <= 1'b1;
          r_tx_st  <= S_STOP;
        end
`endif
        S_STOP: if (r_tx_cnt == BIT_LAST) r_tx_st <= S_IDLE;
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- Display, clock divider, status ----------------
  logic [31:0]           w_disp;
  logic [3:0]            w_nib;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [2:0]            r_digit;
  logic                  r_clk_out;

  always_comb begin
    w_disp = 32'h0;
    if (!w_key_ok) w_disp = 32'hDEAD_DEAD;
    else if (debug) begin
      case (debug_input)
        5'd0:    w_disp = r_disp;
        5'd1:    w_disp = r_prog_word;
        5'd2:    w_disp = {16'h0, r_word_cnt};
        5'd3:    w_disp = {16'h0, r_ovr_err, r_frm_err};
        5'd4:    w_disp = {31'h0, w_key_ok};
        default: w_disp = 32'h0;
      endcase
    end else w_disp = prog ? r_prog_word : r_disp;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_clk_out <= 1'b0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      if (&r_refresh) r_digit <= r_digit + 1'b1;
      r_clk_out <= ~r_clk_out;
    end
  end

  assign w_nib   = w_disp[{r_digit, 2'b00} +: 4];
  assign an      = ~(8'd1 << r_digit);
  assign sev_out = seg7(w_nib);
  assign tx      = r_tx;
  assign clk_out = r_clk_out;
  assign led     = {w_key_ok, prog, w_rxf_empty, (r_tx_st != S_IDLE), r_word_cnt[3:0], r_led_byte};
endmodule

// File: tb/tb_rv_uart_soc_top.sv
// Bench for rv_uart_soc_top: vector table of RX frames, TX echo scoreboard, display decoding.
module tb_rv_uart_soc_top;
  localparam int          CPB        = 16;
  localparam logic [95:0] KEY_VALUE  = 96'h3cf3cf3cf3cf_30c30c_bae_3cf;
  localparam logic [95:0] KEY_LOCKED = {KEY_VALUE[95:8], 8'h00};

  logic        clk = 1'b0;
  logic        Rst, rx, prog, debug;
  logic [4:0]  debug_input;
  logic [95:0] key;
  logic        tx, clk_out;
  logic [6:0]  sev_out;
  logic [7:0]  an;
  logic [15:0] led;

  rv_uart_soc_top #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .REFRESH_BITS(2), .KEY_VALUE(KEY_VALUE)
  ) dut (
    .clk(clk), .Rst(Rst), .rx(rx), .prog(prog), .debug(debug), .debug_input(debug_input),
    .key(key), .tx(tx), .clk_out(clk_out), .sev_out(sev_out), .an(an), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       prog;
    logic       lock;
    logic [7:0] din;
    logic       stopb;
    logic       echo;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [10];
  logic [6:0] seg_tab [16];
  logic [7:0] q [$];
  int         total = 0;
  int         bad   = 0;
  int         epoch = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [3:0] seg2nib(input logic [6:0] s);
    logic [3:0] n;
    n = 4'bxxxx;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == s) n = 4'(k);
    return n;
  endfunction

  task automatic chk_disp(input string nm, input logic [31:0] exp);
    logic [31:0] v;
    logic [7:0]  want_an;
    bit          ok;
    int          t;
    v  = '0;
    ok = 1;
    for (int d = 0; d < 8; d++) begin
      want_an = ~(8'd1 << d);
      t = 0;
      while (an !== want_an && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) ok = 0;
      v[d*4 +: 4] = seg2nib(sev_out);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s scan timeout actual=%h required=%h", nm, v, exp);
    end else check(nm, 0, v, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx = b[j];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // TX monitor: decodes each frame and pops the expected byte
  initial begin : mon
    logic [7:0] b;
    logic       sb;
    int         ep;
    forever begin
      @(negedge tx);
      ep = epoch;
      repeat (CPB / 2) @(posedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(posedge clk);
        #1 b[j] = tx;
      end
`ifdef UART_PARITY_EN
      repeat (CPB) @(posedge clk);
      #1 if (ep == epoch) check("tx_parity", 0, 32'(tx), 32'(^b));
`endif
      repeat (CPB) @(posedge clk);
      #1 sb = tx;
      if (ep == epoch) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected actual=%h required=none", b);
        end else begin
          check("tx_byte", 0, 32'(b), 32'(q.pop_front()));
          check("tx_stop", 0, 32'(sb), 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    //          prog  lock  din    stop  echo  exp(led[7:0]/echo)
    vecs[0] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 8'h55};
    vecs[1] = '{1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA3};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h9A};
    vecs[5] = '{1'b1, 1'b0, 8'hEF, 1'b1, 1'b0, 8'h9A};
    vecs[6] = '{1'b1, 1'b0, 8'hBE, 1'b1, 1'b0, 8'h9A};
    vecs[7] = '{1'b1, 1'b0, 8'hAD, 1'b1, 1'b0, 8'h9A};
    vecs[8] = '{1'b1, 1'b0, 8'hDE, 1'b1, 1'b0, 8'h9A};
    vecs[9] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h9A};

    Rst = 1'b1; rx = 1'b1; prog = 1'b0; debug = 1'b0; debug_input = 5'd0; key = KEY_VALUE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 0, 32'(tx), 32'h1);
    check("rst_an", 0, 32'(an), 32'hFE);
    check("rst_led", 0, 32'(led), 32'hA000);
    check("rst_clk_out", 0, 32'(clk_out), 32'h0);
    Rst = 1'b0;
    @(negedge clk);
    check("clk_out_toggle", 1, 32'(clk_out), 32'h1);
    @(negedge clk);
    check("clk_out_toggle", 2, 32'(clk_out), 32'h0);

    for (int i = 0; i < 10; i++) begin
      prog = vecs[i].prog;
      key  = vecs[i].lock ? KEY_LOCKED : KEY_VALUE;
      if (vecs[i].echo) q.push_back(vecs[i].exp);
      send_byte(vecs[i].din, vecs[i].stopb);
      repeat (4) @(negedge clk);
      check("vec_led_byte", i, 32'(led[7:0]), 32'(vecs[i].exp));
      check("vec_led_hi", i, 32'(led[15:14]), 32'({~vecs[i].lock, vecs[i].prog}));
    end
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("echo_drain", 0, 32'(q.size()), 32'h0);
    check("word_cnt_led", 0, 32'(led[11:8]), 32'h1);

    prog = 1'b1;
    chk_disp("disp_prog_word", 32'hDEAD_BEEF);
    prog = 1'b0;
    chk_disp("disp_reg", 32'hA300_FF9A);
    debug = 1'b1;
    debug_input = 5'd0; chk_disp("dbg0_disp_reg", 32'hA300_FF9A);
    debug_input = 5'd1; chk_disp("dbg1_prog_word", 32'hDEAD_BEEF);
    debug_input = 5'd2; chk_disp("dbg2_word_cnt", 32'h0000_0001);
    debug_input = 5'd3; chk_disp("dbg3_errors", 32'h0000_0001);
    debug_input = 5'd4; chk_disp("dbg4_key_ok", 32'h0000_0001);
    debug_input = 5'd9; chk_disp("dbg_other", 32'h0000_0000);

    key = KEY_LOCKED;
    debug_input = 5'd1;
    chk_disp("locked_disp", 32'hDEAD_DEAD);
    check("locked_led15", 0, 32'(led[15]), 32'h0);
    key = KEY_VALUE;

    // short low pulse on rx must be rejected as a start-bit glitch
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    debug_input = 5'd3;
    chk_disp("glitch_errors", 32'h0000_0001);
    check("glitch_led_byte", 0, 32'(led[7:0]), 32'h9A);

    // back-to-back burst, then reset while the transmitter is mid-frame
    for (int i = 0; i < 10; i++) begin
      q.push_back(8'(i * 17 + 3));
      send_byte(8'(i * 17 + 3), 1'b1);
    end
    t = 0;
    while (tx !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("burst_tx_busy", 0, 32'(tx), 32'h0);
    epoch++;
    Rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midframe_rst_tx", 0, 32'(tx), 32'h1);
    Rst = 1'b0;
    @(negedge clk);
    check("post_rst_led", 0, 32'(led), 32'hA000);
    debug_input = 5'd3; chk_disp("post_rst_errors", 32'h0);
    debug_input = 5'd0; chk_disp("post_rst_disp", 32'h0);
    repeat (400) @(negedge clk);
    check("post_rst_tx_idle", 0, 32'(tx), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
